// File: rtl/cga_vram_arbiter_pkg.sv
// Shared constants for the CGA video SRAM arbiter.
package cga_vram_arbiter_pkg;

  localparam int unsigned VRAM_AW = 19;
  localparam int unsigned VRAM_DW = 8;

  // Counter width able to hold values 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cga_vram_access_timer.sv
// Access-phase counter, PEND wait counter and sticky starvation flag.
module cga_vram_access_timer
  import cga_vram_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned MAX_WAIT      = 31
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_acc_run,
  input  logic i_wait_clr,
  input  logic i_wait_inc,
  output logic o_acc_last_c,
  output logic o_we_phase_c,
  output logic o_starved
);

  localparam int unsigned ACC_W  = cnt_w(ACCESS_CYCLES);
  localparam int unsigned WAIT_W = cnt_w(MAX_WAIT + 1);

  logic [ACC_W-1:0]  r_acc_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_starved;
  logic              w_wait_sat;

  assign o_acc_last_c = (r_acc_cnt == ACC_W'(ACCESS_CYCLES - 1));
  assign o_we_phase_c = (r_acc_cnt <  ACC_W'(ACCESS_CYCLES - 1));
  assign w_wait_sat   = (r_wait_cnt >= WAIT_W'(MAX_WAIT));
  assign o_starved    = r_starved;

  // Access counter restarts whenever the CPU loses the bus or finishes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc_cnt  <= '0;
      r_wait_cnt <= '0;
      r_starved  <= 1'b0;
    end else begin
      if (!i_acc_run || o_acc_last_c)
        r_acc_cnt <= '0;
      else
        r_acc_cnt <= r_acc_cnt + ACC_W'(1);

      if (i_wait_clr)
        r_wait_cnt <= '0;
      else if (i_wait_inc && !w_wait_sat)
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);

      if (i_wait_inc && (r_wait_cnt >= WAIT_W'(MAX_WAIT - 1)))
        r_starved <= 1'b1;
    end
  end

endmodule

// File: rtl/cga_vram_arbiter.sv
// Video SRAM arbiter: pixel fetches always win, one queued CPU access runs in free cycles.
module cga_vram_arbiter
  import cga_vram_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned MAX_WAIT      = 31
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pixel_read,
  input  logic [VRAM_AW-1:0] i_pixel_addr,
  output logic [VRAM_DW-1:0] o_pixel_data,
  input  logic               i_isa_read,
  input  logic               i_isa_write,
  input  logic [VRAM_AW-1:0] i_isa_addr,
  input  logic [VRAM_DW-1:0] i_isa_din,
  output logic [VRAM_DW-1:0] o_isa_dout,
  output logic               o_isa_rdy,
  output logic [VRAM_AW-1:0] o_ram_a,
  output logic               o_ram_we_l,
  output logic [VRAM_DW-1:0] o_ram_d_out,
  output logic               o_ram_d_oe,
  input  logic [VRAM_DW-1:0] i_ram_d_in,
  output logic               o_starved
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [VRAM_AW-1:0] r_addr;
  logic [VRAM_DW-1:0] r_din;
  logic               r_write;
  logic [VRAM_DW-1:0] r_isa_dout;
  logic [VRAM_DW-1:0] r_pixel_data;
  logic               w_strobe;
  logic               w_capture;
  logic               w_wait_clr;
  logic               w_wait_inc;
  logic               w_acc_run;
  logic               w_acc_last;
  logic               w_we_phase;
  logic               w_bus_cpu;

  assign w_strobe = i_isa_read | i_isa_write;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_wait_clr = 1'b0;
    w_wait_inc = 1'b0;
    w_acc_run  = 1'b0;
    case (r_state)
      S_IDLE: if (w_strobe) begin
        w_capture  = 1'b1;
        w_wait_clr = 1'b1;
        w_next     = S_PEND;
      end
      S_PEND: if (!i_pixel_read) w_next = S_ACC;
              else               w_wait_inc = 1'b1;
      // A pixel slot during ACC aborts the access; it restarts from PEND.
      S_ACC: if (i_pixel_read) begin
        w_next = S_PEND;
      end else begin
        w_acc_run = 1'b1;
        if (w_acc_last) w_next = S_DONE;
      end
      S_DONE: if (!w_strobe) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr       <= '0;
      r_din        <= '0;
      r_write      <= 1'b0;
      r_isa_dout   <= '0;
      r_pixel_data <= '0;
    end else begin
      if (w_capture) begin
        r_addr  <= i_isa_addr;
        r_din   <= i_isa_din;
        r_write <= i_isa_write;
      end
      if (w_acc_run && w_acc_last && !r_write) r_isa_dout <= i_ram_d_in;
      if (i_pixel_read) r_pixel_data <= i_ram_d_in;
    end
  end

  cga_vram_access_timer #(
    .ACCESS_CYCLES (ACCESS_CYCLES),
    .MAX_WAIT      (MAX_WAIT)
  ) u_timer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_acc_run    (w_acc_run),
    .i_wait_clr   (w_wait_clr),
    .i_wait_inc   (w_wait_inc),
    .o_acc_last_c (w_acc_last),
    .o_we_phase_c (w_we_phase),
    .o_starved    (o_starved)
  );

  // Reset gates the SRAM controls directly so a write pulse dies immediately.
  assign w_bus_cpu    = (r_state == S_ACC) && !i_pixel_read && !i_reset;
  assign o_ram_a      = w_bus_cpu ? r_addr : i_pixel_addr;
  assign o_ram_d_oe   = w_bus_cpu && r_write;
  assign o_ram_we_l   = !(w_bus_cpu && r_write && w_we_phase);
  assign o_ram_d_out  = r_din;
  assign o_isa_rdy    = i_reset || !(w_strobe && (r_state != S_DONE));
  assign o_isa_dout   = r_isa_dout;
  assign o_pixel_data = r_pixel_data;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter with an SRAM model and read/pixel scoreboards.
module tb_cga_vram_arbiter;

  localparam int unsigned AC   = 2;
  localparam int unsigned MW   = 31;
  localparam logic [18:0] PIX_A = 19'h00400;
  localparam logic [7:0]  PIX_D = 8'hC3;

  logic        clk = 1'b0;
  logic        reset;
  logic        preload;
  logic        pixel_read;
  logic [18:0] pixel_addr;
  logic [7:0]  pixel_data;
  logic        isa_read;
  logic        isa_write;
  logic [18:0] isa_addr;
  logic [7:0]  isa_din;
  logic [7:0]  isa_dout;
  logic        isa_rdy;
  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_d_out;
  logic        ram_d_oe;
  logic [7:0]  ram_d_in;
  logic        starved;

  logic [7:0] sram [0:(1<<19)-1];
  logic [7:0] exp_mem [logic [18:0]];
  logic [7:0] rd_q [$];
  logic [7:0] pix_q [$];
  logic       exp_starved;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  cga_vram_arbiter #(
    .ACCESS_CYCLES (AC),
    .MAX_WAIT      (MW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_pixel_read (pixel_read),
    .i_pixel_addr (pixel_addr),
    .o_pixel_data (pixel_data),
    .i_isa_read   (isa_read),
    .i_isa_write  (isa_write),
    .i_isa_addr   (isa_addr),
    .i_isa_din    (isa_din),
    .o_isa_dout   (isa_dout),
    .o_isa_rdy    (isa_rdy),
    .o_ram_a      (ram_a),
    .o_ram_we_l   (ram_we_l),
    .o_ram_d_out  (ram_d_out),
    .o_ram_d_oe   (ram_d_oe),
    .i_ram_d_in   (ram_d_in),
    .o_starved    (starved)
  );

  // Asynchronous-read, edge-write SRAM
  assign ram_d_in = sram[ram_a];
  always @(posedge clk) begin
    if (preload) begin
      sram[PIX_A]     <= PIX_D;
      sram[19'h00123] <= 8'h11;
    end else if (!ram_we_l && ram_d_oe) begin
      sram[ram_a] <= ram_d_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix_check(input string tag);
    chk({tag, " pixel_data"}, {24'd0, pixel_data}, {24'd0, pix_q.pop_front()});
  endtask

  // One CPU access; pixel_read high for cycles [pix_k, pix_k+pix_len); rdy expected to rise at exp_lat.
  task automatic cpu_txn(input string tag, input logic wr, input logic [18:0] a, input logic [7:0] d,
                         input int pix_k, input int pix_len, input int exp_lat, input int exp_we,
                         input int hold, input int starve_k);
    int   we_low;
    logic pix_prev;
    we_low   = 0;
    pix_prev = 1'b0;
    isa_addr  = a;
    isa_din   = d;
    isa_write = wr;
    isa_read  = ~wr;
    if (wr) exp_mem[a] = d;
    else    rd_q.push_back(exp_mem[a]);
    for (int k = 0; k <= exp_lat; k++) begin
      pixel_read = (k >= pix_k) && (k < pix_k + pix_len);
      if (pix_prev) pix_check(tag);
      pix_prev = pixel_read;
      if (pixel_read) pix_q.push_back(PIX_D);
      if (starve_k >= 0 && k >= starve_k) exp_starved = 1'b1;
      #1;
      chk({tag, " isa_rdy"}, {31'd0, isa_rdy}, {31'd0, k == exp_lat});
      chk({tag, " starved"}, {31'd0, starved}, {31'd0, exp_starved});
      if (pixel_read) begin
        chk({tag, " pix ram_a"}, {13'd0, ram_a}, {13'd0, PIX_A});
        chk({tag, " pix we_l"}, {31'd0, ram_we_l}, 32'd1);
        chk({tag, " pix d_oe"}, {31'd0, ram_d_oe}, 32'd0);
      end
      if (!ram_we_l) begin
        we_low++;
        chk({tag, " wr ram_a"}, {13'd0, ram_a}, {13'd0, a});
        chk({tag, " wr d_out"}, {24'd0, ram_d_out}, {24'd0, d});
        chk({tag, " wr d_oe"}, {31'd0, ram_d_oe}, 32'd1);
      end
      if (isa_rdy && !wr && rd_q.size() > 0)
        chk({tag, " isa_dout"}, {24'd0, isa_dout}, {24'd0, rd_q.pop_front()});
      step();
    end
    pixel_read = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (pix_prev) begin pix_check(tag); pix_prev = 1'b0; end
      #1;
      chk({tag, " hold rdy"}, {31'd0, isa_rdy}, 32'd1);
      chk({tag, " hold we_l"}, {31'd0, ram_we_l}, 32'd1);
      chk({tag, " hold ram_a"}, {13'd0, ram_a}, {13'd0, PIX_A});
      chk({tag, " hold starved"}, {31'd0, starved}, {31'd0, exp_starved});
      step();
    end
    if (pix_prev) pix_check(tag);
    chk({tag, " we_l low cycles"}, we_low, exp_we);
    isa_read  = 1'b0;
    isa_write = 1'b0;
    #1;
    chk({tag, " release rdy"}, {31'd0, isa_rdy}, 32'd1);
    step();
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1; pixel_read = 1'b0; pixel_addr = PIX_A;
    isa_read = 1'b0; isa_write = 1'b0; isa_addr = '0; isa_din = '0;
    exp_starved = 1'b0;
    step(); step();
    chk("rst isa_rdy", {31'd0, isa_rdy}, 32'd1);
    chk("rst we_l", {31'd0, ram_we_l}, 32'd1);
    chk("rst d_oe", {31'd0, ram_d_oe}, 32'd0);
    chk("rst d_out", {24'd0, ram_d_out}, 32'd0);
    chk("rst ram_a", {13'd0, ram_a}, {13'd0, PIX_A});
    chk("rst pixel_data", {24'd0, pixel_data}, 32'd0);
    chk("rst isa_dout", {24'd0, isa_dout}, 32'd0);
    chk("rst starved", {31'd0, starved}, 32'd0);
    preload = 1'b0;
    reset = 1'b0;
    step();

    // Reset during ACC cycle 0 of a write
    isa_write = 1'b1; isa_addr = 19'h00123; isa_din = 8'hA5;
    #1 chk("rmw idle rdy", {31'd0, isa_rdy}, 32'd0);
    step();
    chk("rmw pend rdy", {31'd0, isa_rdy}, 32'd0);
    chk("rmw pend we_l", {31'd0, ram_we_l}, 32'd1);
    step();
    chk("rmw acc we_l", {31'd0, ram_we_l}, 32'd0);
    chk("rmw acc d_oe", {31'd0, ram_d_oe}, 32'd1);
    chk("rmw acc ram_a", {13'd0, ram_a}, 32'h123);
    reset = 1'b1;
    #1;
    chk("rmw rst we_l", {31'd0, ram_we_l}, 32'd1);
    chk("rmw rst d_oe", {31'd0, ram_d_oe}, 32'd0);
    chk("rmw rst rdy", {31'd0, isa_rdy}, 32'd1);
    step();
    isa_write = 1'b0;
    reset = 1'b0;
    #1;
    chk("rmw sram untouched", {24'd0, sram[19'h00123]}, 32'h11);
    chk("rmw starved", {31'd0, starved}, 32'd0);
    step();

    cpu_txn("wr", 1'b1, 19'h00123, 8'h5A, -1, 0, AC + 2, 1, 0, -1);
    cpu_txn("rd", 1'b0, 19'h00123, 8'h00, -1, 0, AC + 2, 0, 0, -1);
    // Pixel slot in ACC cycle 1: lose both ACC cycles plus a PEND cycle
    cpu_txn("rd_pix", 1'b0, 19'h00123, 8'h00, 3, 1, AC + 5, 0, 0, -1);
    cpu_txn("hold", 1'b0, 19'h00123, 8'h00, -1, 0, AC + 2, 0, 10, -1);
    // 39 stalled PEND cycles; starved visible from cycle MW+1
    cpu_txn("starve", 1'b1, 19'h00200, 8'h77, 0, 40, 43, 1, 0, MW + 1);
    cpu_txn("rd200", 1'b0, 19'h00200, 8'h00, -1, 0, AC + 2, 0, 2, -1);

    chk("read queue drained", rd_q.size(), 32'd0);
    chk("pixel queue drained", pix_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
